// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencing controller:
// FSM state encoding, opcode values, ALU operation classes, instruction classes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } insn_cls_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADDR  = 2'b00;
    localparam logic [1:0] ALU_OP_BR    = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

endpackage

// File: rtl/insn_class_dec.sv
// Purpose: map a 7-bit opcode onto an instruction class plus an illegal flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows opcode continuously.
module insn_class_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output insn_cls_t  cls,
    output logic       illegal
);

    always_comb begin
        cls     = CLS_R;
        illegal = 1'b0;
        case (opcode)
            OPC_R:      cls = CLS_R;
            OPC_I:      cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a shared ALU and memory port.
// Latency: R/I/STORE 4, LOAD 5, BRANCH 3 cycles with zero-wait memory; +1 per wait cycle.
// Backpressure: mem_req held until mem_ack; optional ACK_TIMEOUT watchdog traps; CTRL_PERF_CNT_EN adds counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPC_W       = 7,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             trap,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      instret_cnt,
`endif
    output logic [2:0]       state_o
);

    state_t    state, state_nxt;
    insn_cls_t cls_q, cls_dec;
    logic      illegal;
    logic      wd_expired;

    // Opcode field is the RV32 7-bit major opcode; OPC_W is expected to stay 7.
    insn_class_dec u_dec (
        .opcode  (opcode),
        .cls     (cls_dec),
        .illegal (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
            cls_q <= CLS_R;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) cls_q <= cls_dec;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_OP_ADDR;
        alu_src    = 1'b0;
        trap       = 1'b0;
        case (state)
            S_BOOT: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wd_expired) begin
                    state_nxt = S_TRAP;
                end
            end
            S_DECODE: state_nxt = illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    CLS_R: begin
                        alu_op    = ALU_OP_FUNCT;
                        state_nxt = S_WB;
                    end
                    CLS_I: begin
                        alu_op    = ALU_OP_FUNCT;
                        alu_src   = 1'b1;
                        state_nxt = S_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_op    = ALU_OP_ADDR;
                        alu_src   = 1'b1;
                        state_nxt = S_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op    = ALU_OP_BR;
                        pc_src    = 1'b1;
                        pc_write  = zero;
                        state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == CLS_STORE);
                if (mem_ack) begin
                    state_nxt = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
                end else if (wd_expired) begin
                    state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == CLS_LOAD);
                state_nxt  = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: state_nxt = S_TRAP;
        endcase
    end

    assign state_o = state;

    generate
        if (ACK_TIMEOUT > 0) begin : g_wd
            localparam logic [31:0] WD_LAST = 32'(ACK_TIMEOUT - 1);
            logic [31:0] wd_cnt;
            logic        wait_cyc;

            // Derived from state rather than mem_req to keep the FSM block free of feedback.
            assign wait_cyc   = ((state == S_FETCH) || (state == S_MEM)) && !mem_ack;
            assign wd_expired = wait_cyc && (wd_cnt == WD_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_cnt <= '0;
                end else if (wait_cyc && (state_nxt == state)) begin
                    wd_cnt <= wd_cnt + 32'd1;
                end else begin
                    wd_cnt <= '0;
                end
            end
        end else begin : g_no_wd
            assign wd_expired = 1'b0;
        end
    endgenerate

`ifdef CTRL_PERF_CNT_EN
    logic insn_done;

    assign insn_done = (state == S_WB)
                    || ((state == S_MEM) && (cls_q == CLS_STORE) && mem_ack)
                    || ((state == S_EXEC) && (cls_q == CLS_BRANCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if ((state != S_BOOT) && (state != S_TRAP)) cycle_cnt <= cycle_cnt + 32'd1;
            if (insn_done) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule
